aes_spi_scheduler: RTL

- Shares one AES SPI slave pair (cipher slave, inverse-cipher slave) between two requesters, each of which issues encrypt or decrypt jobs.
- Per job: round-robin arbitration, operand latch, serial shift of data then key on mosi, fixed turnaround gap, serial capture of the 128-bit result, one-cycle done pulse to the winning requester.
- Sits between the host-side request logic and the SPI slaves, and replaces the free-running master sequencing with request-driven scheduling.

---
 rtl/aes_spi_scheduler.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_spi_scheduler.sv
// aes_spi_scheduler: round-robin scheduler sharing one AES SPI slave pair
// (cipher / inverse cipher) between two requesters of encrypt/decrypt jobs.
// Per job: grant and latch operands, shift data then key out on mosi, idle
// for GAP_CYCLES, capture the 128-bit result from the selected miso, pulse
// done to the granted requester.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req/op/data/key 0 and 1   requester job inputs (op 1=encrypt, 0=decrypt)
//   gnt0/gnt1, done0/done1    one-cycle grant / completion pulses
//   result, busy              last job result, job in flight
//   mosi, miso_enc, miso_dec  serial link; cs_enc, cs_dec active-low selects
// Optional build macro AES_SCHED_STATS_EN adds stat_enc_cnt/stat_dec_cnt,
// saturating 16-bit counts of completed encrypt/decrypt jobs.
module aes_spi_scheduler #(
   parameter int Nk         = 4,
   parameter int Nr         = 10,
   parameter int GAP_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              op0,
   input  logic [127:0]      data0,
   input  logic [Nk*32-1:0]  key0,
   input  logic              req1,
   input  logic              op1,
   input  logic [127:0]      data1,
   input  logic [Nk*32-1:0]  key1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [127:0]      result,
   output logic              busy,
   output logic              mosi,
   input  logic              miso_enc,
   input  logic              miso_dec,
   output logic              cs_enc,
`ifdef AES_SCHED_STATS_EN
   output logic              cs_dec,
   output logic [15:0]       stat_enc_cnt,
   output logic [15:0]       stat_dec_cnt
`else
   output logic              cs_dec
`endif
);

   localparam int KW = Nk * 32;

   // Nr only configures the slaves; it is checked here against Nk.
   if (!((Nk == 4) || (Nk == 6) || (Nk == 8)) || (Nr != Nk + 6) ||
       (GAP_CYCLES < 1) || (GAP_CYCLES > 15)) begin : g_bad_cfg
      $error("aes_spi_scheduler: illegal Nk/Nr/GAP_CYCLES");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_DATA,
      S_SEND_KEY,
      S_GAP,
      S_RECV,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [7:0]      bit_cnt;
   logic [3:0]      gap_cnt;
   logic [127:0]    data_sh;
   logic [KW-1:0]   key_sh;
   logic [127:0]    rx_sh;
   logic            op_sh;
   logic            owner;
   logic            rr_ptr;
   logic            grant;
   logic            pick;
   logic            miso_sel;
   logic            cs_low;

   assign miso_sel = op_sh ? miso_enc : miso_dec;

   // Arbitration: a lone request wins; on a tie rr_ptr names the winner.
   always_comb begin
      grant = 1'b0;
      pick  = 1'b0;
      if (state == S_IDLE) begin
         if (req0 && req1) begin
            grant = 1'b1;
            pick  = rr_ptr;
         end else if (req0) begin
            grant = 1'b1;
            pick  = 1'b0;
         end else if (req1) begin
            grant = 1'b1;
            pick  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and job-phase outputs.
   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      mosi     = 1'b0;
      cs_low   = 1'b0;
      done0    = 1'b0;
      done1    = 1'b0;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (grant) begin
               state_nx = S_SEND_DATA;
            end
         end
         S_SEND_DATA: begin
            mosi   = data_sh[127];
            cs_low = 1'b1;
            if (bit_cnt == 8'd0) begin
               state_nx = S_SEND_KEY;
            end
         end
         S_SEND_KEY: begin
            mosi   = key_sh[KW-1];
            cs_low = 1'b1;
            if (bit_cnt == 8'd0) begin
               state_nx = S_GAP;
            end
         end
         S_GAP: begin
            cs_low = 1'b1;
            if (gap_cnt == 4'd0) begin
               state_nx = S_RECV;
            end
         end
         S_RECV: begin
            cs_low = 1'b1;
            if (bit_cnt == 8'd0) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            done0    = ~owner;
            done1    = owner;
            state_nx = S_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = S_IDLE;
         end
      endcase
      cs_enc = ~(cs_low & op_sh);
      cs_dec = ~(cs_low & ~op_sh);
   end

   // Datapath: shadow operands, counters, receive shifter, result.
   // Counters reload on every state entry and count down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= 8'd0;
         gap_cnt <= 4'd0;
         data_sh <= '0;
         key_sh  <= '0;
         rx_sh   <= '0;
         op_sh   <= 1'b0;
         owner   <= 1'b0;
         rr_ptr  <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         result  <= '0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (grant) begin
                  owner   <= pick;
                  op_sh   <= pick ? op1 : op0;
                  data_sh <= pick ? data1 : data0;
                  key_sh  <= pick ? key1 : key0;
                  gnt0    <= ~pick;
                  gnt1    <= pick;
                  bit_cnt <= 8'd127;
               end
            end
            S_SEND_DATA: begin
               data_sh <= {data_sh[126:0], 1'b0};
               if (bit_cnt == 8'd0) begin
                  bit_cnt <= 8'(KW - 1);
               end else begin
                  bit_cnt <= bit_cnt - 8'd1;
               end
            end
            S_SEND_KEY: begin
               key_sh <= {key_sh[KW-2:0], 1'b0};
               if (bit_cnt == 8'd0) begin
                  gap_cnt <= 4'(GAP_CYCLES - 1);
               end else begin
                  bit_cnt <= bit_cnt - 8'd1;
               end
            end
            S_GAP: begin
               if (gap_cnt == 4'd0) begin
                  bit_cnt <= 8'd127;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            S_RECV: begin
               rx_sh <= {rx_sh[126:0], miso_sel};
               // Last sample goes straight into result so it is valid
               // together with the done pulse.
               if (bit_cnt == 8'd0) begin
                  result <= {rx_sh[126:0], miso_sel};
               end else begin
                  bit_cnt <= bit_cnt - 8'd1;
               end
            end
            S_DONE: begin
               rr_ptr <= ~owner;
            end
            default: begin
               rr_ptr <= rr_ptr;
            end
         endcase
      end
   end

`ifdef AES_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_enc_cnt <= 16'd0;
         stat_dec_cnt <= 16'd0;
      end else if (state == S_DONE) begin
         if (op_sh && (stat_enc_cnt != 16'hFFFF)) begin
            stat_enc_cnt <= stat_enc_cnt + 16'd1;
         end
         if (!op_sh && (stat_dec_cnt != 16'hFFFF)) begin
            stat_dec_cnt <= stat_dec_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
